lock_attempt_controller: RTL

//   Front-end sequencer between the keypad and the digitalLock state machine.

---
 rtl/lock_attempt_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lock_attempt_controller.sv
// lock_attempt_controller
//   Sits between the keypad and the digitalLock state machine. Raw key inputs
//   are edge-detected, and each valid press goes to the lock as a one-cycle
//   pulse. Presses are grouped into DIGITS-long attempts. After each attempt
//   the lock's locked flag is sampled. After MAX_FAILS consecutive failed
//   attempts the lock is reset and entry is blocked for LOCKOUT_CYCLES.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   key_in       in   [3:0] raw keypad, one bit per key, already synchronised
//   lock_locked  in   locked flag from digitalLock
//   key_out      out  [3:0] key pulses to digitalLock, 0 when idle
//   lock_reset   out  one-cycle reset pulse to digitalLock on lockout entry
//   lockout      out  high while entry is blocked
//   fail_count   out  consecutive failed attempts, saturates at MAX_FAILS
//   digit_count  out  presses forwarded in the current attempt
module lock_attempt_controller #(
    parameter int DIGITS         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RESULT_DELAY   = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [3:0]                         key_in,
    input  logic                               lock_locked,
    output logic [3:0]                         key_out,
    output logic                               lock_reset,
    output logic                               lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
    output logic [$clog2(DIGITS+1)-1:0]        digit_count
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int DW = $clog2(DIGITS + 1);
    localparam int CW = $clog2(RESULT_DELAY + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES);

    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [DW-1:0] DIG_FULL  = DW'(DIGITS);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_FULL = FW'(MAX_FAILS);
    localparam logic [CW-1:0] DLY_LAST  = CW'(RESULT_DELAY);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

    localparam logic [1:0] ENTRY       = 2'd0;
    localparam logic [1:0] WAIT_RESULT = 2'd1;
    localparam logic [1:0] UNLOCKED    = 2'd2;
    localparam logic [1:0] LOCKOUT     = 2'd3;

    logic [1:0]    state;
    logic [3:0]    key_prev;
    logic [CW-1:0] delay_cnt;
    logic [LW-1:0] lock_cnt;
    logic          one_hot;
    logic          press;

    // A press is a one-hot key rising out of an all-idle keypad. Chords and
    // held keys never qualify. A key held across a state change stays
    // silent until it is released.
    assign one_hot = (key_in != 4'b0) && ((key_in & (key_in - 4'd1)) == 4'b0);
    assign press   = (key_prev == 4'b0) && one_hot;

    assign lockout = (state == LOCKOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ENTRY;
            key_prev    <= 4'b0;
            key_out     <= 4'b0;
            lock_reset  <= 1'b0;
            fail_count  <= '0;
            digit_count <= '0;
            delay_cnt   <= '0;
            lock_cnt    <= '0;
        end else begin
            key_prev   <= key_in;
            key_out    <= 4'b0;
            lock_reset <= 1'b0;
            case (state)
                ENTRY: begin
                    if (press) begin
                        key_out <= key_in;
                        if (digit_count >= DIG_LAST) begin
                            digit_count <= DIG_FULL;
                            delay_cnt   <= '0;
                            state       <= WAIT_RESULT;
                        end else begin
                            digit_count <= digit_count + DW'(1);
                        end
                    end
                end
                WAIT_RESULT: begin
                    // delay_cnt is 0 in the cycle that carries the final
                    // key pulse. The lock's flag is sampled RESULT_DELAY
                    // cycles after that pulse.
                    if (delay_cnt == DLY_LAST) begin
                        digit_count <= '0;
                        if (!lock_locked) begin
                            fail_count <= '0;
                            state      <= UNLOCKED;
                        end else if (fail_count >= FAIL_LAST) begin
                            fail_count <= FAIL_FULL;
                            lock_reset <= 1'b1;
                            lock_cnt   <= '0;
                            state      <= LOCKOUT;
                        end else begin
                            fail_count <= fail_count + FW'(1);
                            state      <= ENTRY;
                        end
                    end else begin
                        delay_cnt <= delay_cnt + CW'(1);
                    end
                end
                UNLOCKED: begin
                    // When the lock is open, keys pass through so that it
                    // can be re-locked. These presses are not counted.
                    if (press) begin
                        key_out <= key_in;
                    end
                    if (lock_locked) begin
                        digit_count <= '0;
                        state       <= ENTRY;
                    end
                end
                default: begin
                    // LOCKOUT: lock_cnt is 0 in the entry cycle, so the
                    // window is exactly LOCKOUT_CYCLES long.
                    if (lock_cnt == LOCK_LAST) begin
                        fail_count  <= '0;
                        digit_count <= '0;
                        state       <= ENTRY;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
            endcase
        end
    end

endmodule
